// File: rtl/hexpand16.sv
// Gaussian-pyramid EXPAND: upsamples a LIM_W x LIM_H 16-bit raster 2x in both axes with [1 2 1]/2.
// Define HEXP_ROUND_EN to add round-half-up constants; otherwise the half/quarter terms truncate.
module hexpand16 #(
   parameter logic [15:0] LIM_W = 16'd260,
   parameter logic [15:0] LIM_H = 16'd260
) (
   input  logic        clk,
   input  logic        hresn,
   input  logic        hclr,
   input  logic [15:0] hin,
   input  logic        hin_valid,
   output logic        hin_ready,
   output logic [15:0] hout,
   output logic        hout_valid,
   input  logic        hout_ready,
   output logic        hout_eol,
   output logic        hout_eof,
   output logic        hbusy
);

   localparam int          AW    = (LIM_W <= 16'd2) ? 1 : $clog2(LIM_W);
   localparam logic [16:0] OW    = {LIM_W, 1'b0};
   localparam logic [AW-1:0] CLAST = AW'(LIM_W - 16'd1);
`ifdef HEXP_ROUND_EN
   localparam logic [16:0] K1 = 17'd1;
   localparam logic [17:0] K2 = 18'd2;
`else
   localparam logic [16:0] K1 = 17'd0;
   localparam logic [17:0] K2 = 18'd0;
`endif

   typedef enum logic [2:0] {IDLE, LOAD, EVEN, ODD, LAST_EVEN, LAST_ODD} state_t;

   state_t      state_q, state_d;
   logic [15:0] icol_q, icol_d, irow_q, irow_d;
   logic [16:0] ocol_q, ocol_d;
   logic        ld_sel_q, ld_sel_d;
   logic [15:0] hout_q, hout_d;
   logic        vld_q, vld_d, eol_q, eol_d, eof_q, eof_d, busy_q, busy_d;

   logic [15:0] buf0 [0:LIM_W-1];
   logic [15:0] buf1 [0:LIM_W-1];

   logic          in_xfer, out_xfer, row_end, gen_st, out_load, p_sel;
   logic [AW-1:0] c, cn;
   logic [15:0]   pc, pn, qc, qn, pix;
   logic [16:0]   hs, vs;
   logic [17:0]   qs;

   assign hin_ready  = (state_q == LOAD);
   assign hout       = hout_q;
   assign hout_valid = vld_q;
   assign hout_eol   = eol_q;
   assign hout_eof   = eof_q;
   assign hbusy      = busy_q;

   assign in_xfer  = hin_ready & hin_valid;
   assign out_xfer = vld_q & hout_ready;
   assign row_end  = out_xfer & eol_q;
   assign gen_st   = (state_q == EVEN) || (state_q == ODD) ||
                     (state_q == LAST_EVEN) || (state_q == LAST_ODD);
   // A row's generation stops once its eol pixel is registered; the state
   // only moves on when that pixel is actually taken downstream.
   assign out_load = gen_st && (ocol_q != OW) && (!vld_q || hout_ready);

   // Q is always the buffer loaded last; in the bottom rows it doubles as P.
   assign p_sel = ((state_q == LAST_EVEN) || (state_q == LAST_ODD)) ? ld_sel_q : ~ld_sel_q;
   assign c     = ocol_q[AW:1];
   assign cn    = (c == CLAST) ? c : c + AW'(1);
   assign pc    = p_sel    ? buf1[c]  : buf0[c];
   assign pn    = p_sel    ? buf1[cn] : buf0[cn];
   assign qc    = ld_sel_q ? buf1[c]  : buf0[c];
   assign qn    = ld_sel_q ? buf1[cn] : buf0[cn];

   assign hs = {1'b0, pc} + {1'b0, pn} + K1;
   assign vs = {1'b0, pc} + {1'b0, qc} + K1;
   assign qs = {2'b0, pc} + {2'b0, pn} + {2'b0, qc} + {2'b0, qn} + K2;

   always_comb begin
      pix = pc;
      if (!ocol_q[0])
         pix = (state_q == ODD) ? 16'(vs >> 1) : pc;
      else
         pix = (state_q == ODD) ? 16'(qs >> 2) : 16'(hs >> 1);
   end

   always_comb begin
      state_d  = state_q;
      icol_d   = icol_q;
      irow_d   = irow_q;
      ocol_d   = ocol_q;
      ld_sel_d = ld_sel_q;
      hout_d   = hout_q;
      vld_d    = vld_q;
      eol_d    = eol_q;
      eof_d    = eof_q;
      busy_d   = busy_q;
      if (out_xfer) vld_d = 1'b0;
      if (out_load) begin
         hout_d = pix;
         vld_d  = 1'b1;
         eol_d  = (ocol_q == OW - 17'd1);
         eof_d  = (state_q == LAST_ODD) && (ocol_q == OW - 17'd1);
         ocol_d = ocol_q + 17'd1;
      end
      if (in_xfer) busy_d = 1'b1;
      case (state_q)
         IDLE: begin
            state_d  = LOAD;
            icol_d   = 16'd0;
            irow_d   = 16'd0;
            ocol_d   = 17'd0;
            ld_sel_d = 1'b0;
         end
         LOAD: begin
            if (in_xfer) begin
               if (icol_q == LIM_W - 16'd1) begin
                  icol_d = 16'd0;
                  irow_d = irow_q + 16'd1;
                  if (irow_q != 16'd0)     state_d  = EVEN;
                  else if (LIM_H == 16'd1) state_d  = LAST_EVEN;
                  else                     ld_sel_d = ~ld_sel_q;
               end else begin
                  icol_d = icol_q + 16'd1;
               end
            end
         end
         EVEN: if (row_end) begin
            state_d = ODD;
            ocol_d  = 17'd0;
         end
         ODD: if (row_end) begin
            ocol_d = 17'd0;
            // irow_q is one past the row just consumed as Q
            if (irow_q < LIM_H) begin
               state_d  = LOAD;
               ld_sel_d = ~ld_sel_q;
            end else begin
               state_d = LAST_EVEN;
            end
         end
         LAST_EVEN: if (row_end) begin
            state_d = LAST_ODD;
            ocol_d  = 17'd0;
         end
         LAST_ODD: if (row_end) begin
            state_d = IDLE;
            ocol_d  = 17'd0;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (hclr) begin
         state_d  = IDLE;
         icol_d   = 16'd0;
         irow_d   = 16'd0;
         ocol_d   = 17'd0;
         ld_sel_d = 1'b0;
         hout_d   = 16'd0;
         vld_d    = 1'b0;
         eol_d    = 1'b0;
         eof_d    = 1'b0;
         busy_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge hresn) begin
      if (!hresn) begin
         state_q  <= IDLE;
         icol_q   <= 16'd0;
         irow_q   <= 16'd0;
         ocol_q   <= 17'd0;
         ld_sel_q <= 1'b0;
         hout_q   <= 16'd0;
         vld_q    <= 1'b0;
         eol_q    <= 1'b0;
         eof_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         icol_q   <= icol_d;
         irow_q   <= irow_d;
         ocol_q   <= ocol_d;
         ld_sel_q <= ld_sel_d;
         hout_q   <= hout_d;
         vld_q    <= vld_d;
         eol_q    <= eol_d;
         eof_q    <= eof_d;
         busy_q   <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_xfer) begin
         if (ld_sel_q) buf1[icol_q[AW-1:0]] <= hin;
         else          buf0[icol_q[AW-1:0]] <= hin;
      end
   end

endmodule

// File: tb/tb_hexpand16.sv
// Bench for hexpand16: a 4x2 instance and a 2x1 instance share stimulus; expected
// pixels come from a table or from a bilinear 2x upsampling model with edge replication.
module tb_hexpand16;

   logic        clk = 1'b0;
   logic        hresn, hclr, hin_valid, hout_ready;
   logic [15:0] hin;
   int          sel;

   logic        a_vin, a_rdy_in, b_vin, b_rdy_in;
   logic        a_hin_ready, a_hout_valid, a_eol, a_eof, a_busy;
   logic        b_hin_ready, b_hout_valid, b_eol, b_eof, b_busy;
   logic [15:0] a_hout, b_hout;
   logic        o_hin_ready, o_hout_valid, o_eol, o_eof, o_busy;
   logic [15:0] o_hout;

   int errors = 0;
   int checks = 0;

   logic [15:0] pix_q[$];
   logic [15:0] exp_q[$];

   typedef struct {
      logic [0:7][15:0]  px;
      logic [0:31][15:0] ex;
      int                vmode;
      int                rmode;
   } vec_t;
   vec_t vt[4];

   always #5 clk = ~clk;

   assign a_vin    = hin_valid & (sel == 0);
   assign a_rdy_in = hout_ready & (sel == 0);
   assign b_vin    = hin_valid & (sel != 0);
   assign b_rdy_in = hout_ready & (sel != 0);

   hexpand16 #(.LIM_W(16'd4), .LIM_H(16'd2)) u_a (
      .clk(clk), .hresn(hresn), .hclr(hclr), .hin(hin), .hin_valid(a_vin),
      .hin_ready(a_hin_ready), .hout(a_hout), .hout_valid(a_hout_valid),
      .hout_ready(a_rdy_in), .hout_eol(a_eol), .hout_eof(a_eof), .hbusy(a_busy));

   hexpand16 #(.LIM_W(16'd2), .LIM_H(16'd1)) u_b (
      .clk(clk), .hresn(hresn), .hclr(hclr), .hin(hin), .hin_valid(b_vin),
      .hin_ready(b_hin_ready), .hout(b_hout), .hout_valid(b_hout_valid),
      .hout_ready(b_rdy_in), .hout_eol(b_eol), .hout_eof(b_eof), .hbusy(b_busy));

   assign o_hin_ready  = (sel != 0) ? b_hin_ready  : a_hin_ready;
   assign o_hout_valid = (sel != 0) ? b_hout_valid : a_hout_valid;
   assign o_hout       = (sel != 0) ? b_hout       : a_hout;
   assign o_eol        = (sel != 0) ? b_eol        : a_eol;
   assign o_eof        = (sel != 0) ? b_eof        : a_eof;
   assign o_busy       = (sel != 0) ? b_busy       : a_busy;

   task automatic chk(input string nm, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end
   endtask

   // Each output pixel is the rounded average of the 2x2 input neighbourhood
   // (x/2, y/2)..(x/2 + x%2, y/2 + y%2), clamped at the right and bottom edges.
   task automatic model(input int w, input int h);
      int ra, rb, ca, cb, s, rnd;
`ifdef HEXP_ROUND_EN
      rnd = 2;
`else
      rnd = 0;
`endif
      exp_q.delete();
      for (int y = 0; y < 2*h; y++)
         for (int x = 0; x < 2*w; x++) begin
            ra = y / 2; rb = ra + (y % 2); if (rb > h-1) rb = h-1;
            ca = x / 2; cb = ca + (x % 2); if (cb > w-1) cb = w-1;
            s = int'(pix_q[ra*w+ca]) + int'(pix_q[ra*w+cb]) +
                int'(pix_q[rb*w+ca]) + int'(pix_q[rb*w+cb]) + rnd;
            exp_q.push_back(16'(s >> 2));
         end
   endtask

   task automatic run_frame(input string nm, input int s, input int vmode, input int rmode);
      int w, ip, op, cyc, last_in, first_out, n_out;
      bit stall, ovl;
      logic [15:0] ph;
      logic pe, pf;
      w = (s != 0) ? 2 : 4;
      n_out = exp_q.size();
      sel = s; ip = 0; op = 0; cyc = 0; last_in = -1; first_out = -1;
      stall = 0; ovl = 0; ph = 16'h0; pe = 1'b0; pf = 1'b0;
      while (op < n_out && cyc < 3000) begin
         @(negedge clk);
         if (stall) begin
            checks++;
            if (o_hout !== ph || o_eol !== pe || o_eof !== pf) begin
               errors++;
               $display("FAIL %s stall-hold cyc=%0d got=%h/%b/%b required=%h/%b/%b",
                        nm, cyc, o_hout, o_eol, o_eof, ph, pe, pf);
            end
         end
         hin_valid  = (ip < pix_q.size()) && (vmode == 0 || $urandom_range(0, 2) != 0);
         hin        = (ip < pix_q.size()) ? pix_q[ip] : 16'h0;
         hout_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : ($urandom_range(0, 2) != 0);
         #1;
         if (o_hin_ready && o_hout_valid) ovl = 1;
         if (hin_valid && o_hin_ready) begin
            ip++;
            if (ip == pix_q.size()) last_in = cyc;
         end
         if (o_hout_valid && first_out < 0) first_out = cyc;
         if (o_hout_valid && hout_ready) begin
            chk($sformatf("%s px%0d", nm, op), int'(o_hout), int'(exp_q[op]));
            chk($sformatf("%s eol%0d", nm, op), int'(o_eol), int'((op % (2*w)) == 2*w-1));
            chk($sformatf("%s eof%0d", nm, op), int'(o_eof), int'(op == n_out-1));
            if (op == n_out-1) chk($sformatf("%s busy-at-eof", nm), int'(o_busy), 1);
            op++;
         end
         stall = o_hout_valid && !hout_ready;
         ph = o_hout; pe = o_eol; pf = o_eof;
         cyc++;
      end
      chk($sformatf("%s pixels-seen", nm), op, n_out);
      @(negedge clk);
      hin_valid = 1'b0; hout_ready = 1'b0;
      #1;
      chk($sformatf("%s busy-after-eof", nm), int'(o_busy), 0);
      chk($sformatf("%s valid-after-eof", nm), int'(o_hout_valid), 0);
      chk($sformatf("%s latency", nm), first_out - last_in, 2);
      chk($sformatf("%s in-out-overlap", nm), int'(ovl), 0);
   endtask

   task automatic load_vec(input int v);
      pix_q.delete(); exp_q.delete();
      for (int j = 0; j < 8; j++)  pix_q.push_back(vt[v].px[j]);
      for (int j = 0; j < 32; j++) exp_q.push_back(vt[v].ex[j]);
   endtask

   task automatic feed(input int n);
      int ip, cyc;
      ip = 0; cyc = 0;
      while (ip < n && cyc < 100) begin
         @(negedge clk);
         hin_valid = 1'b1; hin = pix_q[ip];
         #1;
         if (o_hin_ready) ip++;
         cyc++;
      end
      chk("feed-accepted", ip, n);
      @(negedge clk);
      hin_valid = 1'b0;
   endtask

   initial begin
      int w, h, cyc;
      hresn = 1'b0; hclr = 1'b0; hin_valid = 1'b0; hout_ready = 1'b0; hin = 16'h0; sel = 0;

      vt[0].px = {16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700};
      vt[0].ex = {16'd0,   16'd50,  16'd100, 16'd150, 16'd200, 16'd250, 16'd300, 16'd300,
                  16'd200, 16'd250, 16'd300, 16'd350, 16'd400, 16'd450, 16'd500, 16'd500,
                  16'd400, 16'd450, 16'd500, 16'd550, 16'd600, 16'd650, 16'd700, 16'd700,
                  16'd400, 16'd450, 16'd500, 16'd550, 16'd600, 16'd650, 16'd700, 16'd700};
      vt[0].vmode = 0; vt[0].rmode = 0;
      vt[1] = vt[0];
      vt[1].rmode = 1;
      vt[2].px = {16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
`ifdef HEXP_ROUND_EN
      vt[2].ex = {16'd0, 16'd1, 16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1,
                  16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1,
                  128'd0, 128'd0};
`else
      vt[2].ex = {16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1,
                  128'd0, 128'd0, 128'd0};
`endif
      vt[2].vmode = 0; vt[2].rmode = 0;
      for (int j = 0; j < 8; j++)  vt[3].px[j] = 16'hFFFF;
      for (int j = 0; j < 32; j++) vt[3].ex[j] = 16'hFFFF;
      vt[3].vmode = 1; vt[3].rmode = 2;

      repeat (2) @(negedge clk);
      #1;
      chk("rst hout", int'(a_hout), 0);
      chk("rst valid", int'(a_hout_valid), 0);
      chk("rst eol", int'(a_eol), 0);
      chk("rst eof", int'(a_eof), 0);
      chk("rst busy", int'(a_busy), 0);
      chk("rst hin_ready", int'(a_hin_ready), 0);
      chk("rst b hin_ready", int'(b_hin_ready), 0);
      @(negedge clk);
      hresn = 1'b1;

      for (int v = 0; v < 4; v++) begin
         load_vec(v);
         run_frame($sformatf("vec%0d", v), 0, vt[v].vmode, vt[v].rmode);
      end

      pix_q = '{16'd10, 16'd20};
      exp_q = '{16'd10, 16'd15, 16'd20, 16'd20, 16'd10, 16'd15, 16'd20, 16'd20};
      run_frame("h1", 1, 0, 0);

      // synchronous abort after five input pixels, then a clean frame
      sel = 0; hout_ready = 1'b1;
      load_vec(0);
      feed(5);
      #1;
      chk("clr busy-before", int'(a_busy), 1);
      hclr = 1'b1;
      @(negedge clk);
      #1;
      chk("clr hin_ready", int'(a_hin_ready), 0);
      chk("clr busy", int'(a_busy), 0);
      chk("clr valid", int'(a_hout_valid), 0);
      hclr = 1'b0;
      run_frame("post-clr", 0, 0, 0);

      // asynchronous reset while an output pixel is pending
      load_vec(3);
      hout_ready = 1'b0;
      feed(8);
      cyc = 0;
      while (!a_hout_valid && cyc < 20) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk("arst pending-valid", int'(a_hout_valid), 1);
      chk("arst pending-hout", int'(a_hout), 16'hFFFF);
      #2;
      hresn = 1'b0;
      #1;
      chk("arst valid", int'(a_hout_valid), 0);
      chk("arst hout", int'(a_hout), 0);
      chk("arst busy", int'(a_busy), 0);
      chk("arst hin_ready", int'(a_hin_ready), 0);
      @(negedge clk);
      hresn = 1'b1;
      load_vec(0);
      run_frame("post-rst", 0, 0, 0);

      for (int f = 0; f < 6; f++) begin
         w = (f % 2 != 0) ? 2 : 4;
         h = (f % 2 != 0) ? 1 : 2;
         pix_q.delete();
         for (int i = 0; i < w*h; i++) pix_q.push_back(16'($urandom_range(0, 65535)));
         model(w, h);
         run_frame($sformatf("rnd%0d", f), f % 2, 1, 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
